// File: rtl/uart_pkg.sv
// Shared types for the UART receive path: deserializer state encoding and
// the byte type carried through the receive FIFO.
// Optional feature macro: UART_RX_PARITY_EN (even-parity bit between data and stop).
package uart_pkg;

   typedef logic [7:0] uart_byte_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
`ifdef UART_RX_PARITY_EN
      ST_PARITY,
`endif
      ST_STOP,
      ST_WAIT_IDLE
   } uart_state_t;

`ifdef UART_RX_PARITY_EN
   // Value the parity bit must take so that data plus parity has an even count of ones.
   function automatic logic even_parity(input uart_byte_t data);
      return ^data;
   endfunction
`endif

endpackage

// File: rtl/uart_rx_sync_fifo.sv
// Synchronous byte FIFO for received UART data. Head byte is presented
// combinationally and forced to zero while empty. A push while full is
// accepted only if a pop happens in the same cycle.
module uart_rx_sync_fifo
   import uart_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       push,
   input  uart_byte_t push_data,
   input  logic       pop,
   output uart_byte_t head_data,
   output logic       full,
   output logic       empty
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] DEPTH_CNT = (AW+1)'(FIFO_DEPTH);

   uart_byte_t    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == DEPTH_CNT);
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   assign head_data = empty ? '0 : mem[rd_ptr];

   // Pointer and occupancy bookkeeping; pointers wrap naturally at FIFO_DEPTH.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage array; contents are don't-care while empty, so no reset.
   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined) with a
// byte FIFO and sticky frame_error / overrun flags.
// Optional feature macro: UART_RX_PARITY_EN.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int unsigned CYCLES_PER_BIT = 434,
   parameter int unsigned FIFO_DEPTH     = 8
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       uart_rx,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       frame_error,
   output logic       overrun,
   input  logic       clear_errors
);

   localparam logic [15:0] HALF_LOAD = 16'(CYCLES_PER_BIT / 2 - 1);
   localparam logic [15:0] BIT_LOAD  = 16'(CYCLES_PER_BIT - 1);

   logic        sync1;
   logic        sync2;
   logic        sync_prev;
   logic        fall;

   uart_state_t state;
   uart_state_t state_nxt;
   logic [15:0] cnt;
   logic [15:0] cnt_nxt;
   logic [2:0]  bit_idx;
   logic [2:0]  bit_idx_nxt;
   uart_byte_t  shreg;
   uart_byte_t  shreg_nxt;
`ifdef UART_RX_PARITY_EN
   logic        par_err;
   logic        par_err_nxt;
`endif

   logic        push;
   logic        frame_evt;
   logic        overrun_evt;
   logic        pop;
   logic        fifo_full;
   logic        fifo_empty;
   uart_byte_t  head_data;

   assign fall = sync_prev && !sync2;

   // Two-flop synchronizer plus a delayed copy for falling-edge detection.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         sync1     <= 1'b1;
         sync2     <= 1'b1;
         sync_prev <= 1'b1;
      end else begin
         sync1     <= uart_rx;
         sync2     <= sync1;
         sync_prev <= sync2;
      end
   end

   // Deserializer state, bit timer, bit index and shift register.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shreg   <= '0;
`ifdef UART_RX_PARITY_EN
         par_err <= 1'b0;
`endif
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         bit_idx <= bit_idx_nxt;
         shreg   <= shreg_nxt;
`ifdef UART_RX_PARITY_EN
         par_err <= par_err_nxt;
`endif
      end
   end

   // Next-state logic: every sample is taken when the bit timer reaches zero.
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      bit_idx_nxt = bit_idx;
      shreg_nxt   = shreg;
      push        = 1'b0;
      frame_evt   = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_nxt = par_err;
`endif
      case (state)
         ST_IDLE: begin
            if (fall) begin
               state_nxt = ST_START;
               cnt_nxt   = HALF_LOAD;
            end
         end
         ST_START: begin
            if (cnt != '0) begin
               cnt_nxt = cnt - 16'd1;
            end else if (!sync2) begin
               state_nxt   = ST_DATA;
               cnt_nxt     = BIT_LOAD;
               bit_idx_nxt = '0;
`ifdef UART_RX_PARITY_EN
               par_err_nxt = 1'b0;
`endif
            end else begin
               state_nxt = ST_IDLE;
            end
         end
         ST_DATA: begin
            if (cnt != '0) begin
               cnt_nxt = cnt - 16'd1;
            end else begin
               shreg_nxt   = {sync2, shreg[7:1]};
               cnt_nxt     = BIT_LOAD;
               bit_idx_nxt = bit_idx + 3'd1;
               if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  state_nxt = ST_PARITY;
`else
                  state_nxt = ST_STOP;
`endif
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         ST_PARITY: begin
            if (cnt != '0) begin
               cnt_nxt = cnt - 16'd1;
            end else begin
               if (sync2 != even_parity(shreg)) begin
                  par_err_nxt = 1'b1;
                  frame_evt   = 1'b1;
               end
               cnt_nxt   = BIT_LOAD;
               state_nxt = ST_STOP;
            end
         end
`endif
         ST_STOP: begin
            if (cnt != '0) begin
               cnt_nxt = cnt - 16'd1;
            end else if (sync2) begin
`ifdef UART_RX_PARITY_EN
               push = !par_err;
`else
               push = 1'b1;
`endif
               state_nxt = ST_IDLE;
            end else begin
               frame_evt = 1'b1;
               state_nxt = ST_WAIT_IDLE;
            end
         end
         ST_WAIT_IDLE: begin
            if (sync2) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign rx_valid    = !fifo_empty;
   assign rx_data     = head_data;
   assign pop         = rx_valid && rx_ready;
   assign overrun_evt = push && fifo_full && !pop;

   uart_rx_sync_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock     (clock),
      .reset_n   (reset_n),
      .push      (push),
      .push_data (shreg),
      .pop       (pop),
      .head_data (head_data),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // Sticky error flags: a new event in the same cycle overrides clear_errors.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         frame_error <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         if (frame_evt)         frame_error <= 1'b1;
         else if (clear_errors) frame_error <= 1'b0;
         if (overrun_evt)       overrun <= 1'b1;
         else if (clear_errors) overrun <= 1'b0;
      end
   end

endmodule
